// File: rtl/regfile_loader.sv
// Streams words into consecutive register-file entries via the write port.
// Define REGFILE_LOADER_VERIFY_EN to add an XOR read-back check on port 1.
module regfile_loader #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_reg,
  input  logic [ADDR_W:0]   count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] read_reg_1,
  input  logic [DATA_W-1:0] read_data_1,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
`ifdef REGFILE_LOADER_VERIFY_EN
    S_VERIFY,
`endif
    S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]     wcnt_q, wcnt_d;
  logic [DATA_W-1:0]   wxor_q, wxor_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic                accept;

`ifdef REGFILE_LOADER_VERIFY_EN
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [ADDR_W:0]     ridx_q, ridx_d;
  logic [DATA_W-1:0]   rxor_q, rxor_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q  <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      wxor_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
`ifdef REGFILE_LOADER_VERIFY_EN
      raddr_q <= '0;
      ridx_q  <= '0;
      rxor_q  <= '0;
`endif
    end else begin
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      wxor_q  <= wxor_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
`ifdef REGFILE_LOADER_VERIFY_EN
      raddr_q <= raddr_d;
      ridx_q  <= ridx_d;
      rxor_q  <= rxor_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    wcnt_d   = wcnt_q;
    wxor_d   = wxor_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
`ifdef REGFILE_LOADER_VERIFY_EN
    raddr_d  = raddr_q;
    ridx_d   = ridx_q;
    rxor_d   = rxor_q;
`endif
    in_ready = (state_q == S_LOAD) && (wcnt_q < cnt_q);
    accept   = in_valid && in_ready;
    busy     = (state_q != S_IDLE) && (state_q != S_FINISH);
    done     = (state_q == S_FINISH);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (1'b1)
            (count == '0): begin
              err_d   = 1'b0;
              wcnt_d  = '0;
              state_d = S_FINISH;
            end
            (count > MAX_CNT): begin
              err_d   = 1'b1;
              state_d = S_FINISH;
            end
            default: begin
              base_d  = base_reg;
              cnt_d   = count;
              err_d   = 1'b0;
              wcnt_d  = '0;
              wxor_d  = '0;
              state_d = S_LOAD;
            end
          endcase
        end
      end
      S_LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = base_q + wcnt_q[ADDR_W-1:0];
          wdata_d = in_data;
          wcnt_d  = wcnt_q + 1'b1;
          wxor_d  = wxor_q ^ in_data;
        end else if (wcnt_q == cnt_q) begin
          // Final write is on the port this cycle; leave next cycle.
`ifdef REGFILE_LOADER_VERIFY_EN
          raddr_d = base_q;
          ridx_d  = '0;
          rxor_d  = '0;
          state_d = S_VERIFY;
`else
          state_d = S_FINISH;
`endif
        end
      end
`ifdef REGFILE_LOADER_VERIFY_EN
      S_VERIFY: begin
        rxor_d  = rxor_q ^ read_data_1;
        raddr_d = raddr_q + 1'b1;
        ridx_d  = ridx_q + 1'b1;
        if (ridx_q == cnt_q - 1'b1) begin
          if ((rxor_q ^ read_data_1) != wxor_q) begin
            err_d = 1'b1;
          end
          state_d = S_FINISH;
        end
      end
`endif
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign write_reg     = waddr_q;
  assign write_data    = wdata_q;
  assign RegWrite      = we_q;
  assign error         = err_q;
  assign words_written = wcnt_q;

`ifdef REGFILE_LOADER_VERIFY_EN
  assign read_reg_1 = raddr_q;
`else
  logic unused_rd;
  assign unused_rd  = ^read_data_1;
  assign read_reg_1 = '0;
`endif

endmodule

// File: tb/tb_regfile_loader.sv
// Scoreboard bench for regfile_loader with an attached register-file model.
// Honours REGFILE_LOADER_VERIFY_EN for verify latency and error checks.
module tb_regfile_loader;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_reg;
  logic [AW:0]   count;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic          RegWrite;
  logic [AW-1:0] read_reg_1;
  logic [DW-1:0] read_data_1;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_written;

  regfile_loader #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset), .start(start),
    .base_reg(base_reg), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .write_reg(write_reg), .write_data(write_data),
    .RegWrite(RegWrite), .read_reg_1(read_reg_1),
    .read_data_1(read_data_1), .busy(busy), .done(done),
    .error(error), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file; inj corrupts bit 0 of anything stored into reg 2.
  logic [DW-1:0] rf [NR];
  bit inj = 1'b0;
  always @(posedge clk)
    if (RegWrite)
      rf[write_reg] <= (inj && write_reg == 3'd2) ?
                       (write_data ^ 32'd1) : write_data;
  assign read_data_1 = rf[read_reg_1];

  logic [DW-1:0] ref_rf [NR];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t sbq[$];

  bit tb_acc = 1'b0;
  bit acc_d1 = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] wq[$];
  bit vq[$];
  logic [DW-1:0] wtmp;

`ifdef REGFILE_LOADER_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Monitor: a write must follow each acceptance by one cycle, in order.
  always @(negedge clk) begin
    wr_t e;
    if (RegWrite || acc_d1) begin
      n_cmp++;
      if (!(RegWrite && acc_d1)) begin
        n_err++;
        $display("FAIL write_timing: RegWrite=%0b expected=%0b t=%0t",
                 RegWrite, acc_d1, $time);
      end
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL write_spurious: addr=%0d data=0x%0h t=%0t",
                 write_reg, write_data, $time);
      end else begin
        e = sbq.pop_front();
        if (RegWrite) begin
          n_cmp++;
          if (write_reg !== e.a || write_data !== e.d) begin
            n_err++;
            $display("FAIL write_data: got %0d/0x%0h expected %0d/0x%0h",
                     write_reg, write_data, e.a, e.d);
          end
        end
      end
    end
    acc_d1 = tb_acc;
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_write_reg"}, 32'(write_reg), 0);
    chk({tag, "_write_data"}, write_data, 0);
    chk({tag, "_RegWrite"}, 32'(RegWrite), 0);
    chk({tag, "_read_reg_1"}, 32'(read_reg_1), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_words"}, 32'(words_written), 0);
  endtask

  task automatic issue_start(input int base, input int cnt);
    @(posedge clk); #1;
    start    = 1'b1;
    base_reg = 3'(base);
    count    = 4'(cnt);
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic run_load(input int base, input int cnt, input int gap);
    int idx = 0;
    int k = 0;
    int n = 0;
    bit v;
    bit wrote2 = 1'b0;
    logic [DW-1:0] w;
    issue_start(base, cnt);
    if (cnt == 0 || cnt > NR) begin
      @(negedge clk);
      chk("short_done", 32'(done), 1);
      chk("short_busy", 32'(busy), 0);
      if (cnt > NR) chk("illegal_error", 32'(error), 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("short_done_drop", 32'(done), 0);
      return;
    end
    while (idx < cnt && n < 200) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      v = (vq.size() > 0) ? vq.pop_front() : ($urandom_range(99) >= gap);
      w = (v && wq.size() > 0) ? wq.pop_front() : $urandom();
      in_valid = v;
      in_data  = w;
      tb_acc   = v;
      if (v) begin
        sbq.push_back('{a: 3'(base + idx), d: w});
        ref_rf[(base + idx) % NR] = w;
        if ((base + idx) % NR == 2) wrote2 = 1'b1;
        k = cyc;
      end
      @(negedge clk);
      chk("in_ready", 32'(in_ready), 1);
      chk("busy", 32'(busy), 1);
      if (v) idx++;
      n++;
    end
    chk("accept_count", idx, cnt);
    n = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      tb_acc   = 1'b0;
      @(negedge clk);
      n++;
      if (n == 1) chk("ready_drop", 32'(in_ready), 0);
    end while (!done && n < 40);
    chk("done_latency", cyc - k, 2 + (VER ? cnt : 0));
    chk("done_busy", 32'(busy), 0);
    chk("error", 32'(error), (VER && inj && wrote2) ? 1 : 0);
    chk("words_written", 32'(words_written), cnt);
    chk("sb_empty", sbq.size(), 0);
    if (inj && wrote2) ref_rf[2] = ref_rf[2] ^ 32'd1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_drop", 32'(done), 0);
    for (int i = 0; i < NR; i++)
      chk($sformatf("rf%0d", i), rf[i], ref_rf[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    base_reg = '0;
    count    = '0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("por");
    reset = 1'b0;

    for (int i = 1; i <= 8; i++) wq.push_back(32'(i));
    run_load(0, 8, 0);

    wq.push_back(32'hAAAA0000);
    wq.push_back(32'hBBBB0000);
    wq.push_back(32'hCCCC0000);
    run_load(6, 3, 0);

    vq = '{1, 0, 0, 1, 1, 0, 1};
    run_load(1, 4, 0);

    run_load(3, 9, 0);
    run_load(2, 0, 0);

    inj = 1'b1;
    run_load(0, 8, 0);
    inj = 1'b0;

    // Reset after three of eight words have landed in the file.
    issue_start(0, 8);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      wtmp = $urandom();
      in_valid = 1'b1;
      in_data  = wtmp;
      tb_acc   = 1'b1;
      sbq.push_back('{a: 3'(i), d: wtmp});
      ref_rf[i] = wtmp;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tb_acc   = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk_reset("mid");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++)
      chk($sformatf("rst_keep%0d", i), rf[i], ref_rf[i]);
    chk("rst_sb_empty", sbq.size(), 0);
    run_load(5, 2, 0);

    for (int t = 0; t < 8; t++)
      run_load($urandom_range(NR - 1), $urandom_range(NR, 1), 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_loader.md
# regfile_loader

Sequential write-port master for the MiniMIPS register file. It accepts a stream of 32-bit words over a valid/ready handshake and writes them into consecutive registers through the file's `write_reg`/`write_data`/`RegWrite` port. It provides hardware register initialisation at boot and debug preload in place of file-based loading. An optional read-back pass checks the loaded contents through read port 1.

## Interface
Parameters:
- `DATA_W`, 32, register width.
- `ADDR_W`, 3, register address width.
- `NUM_REGS`, 8, number of registers (2**ADDR_W).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE.
- `base_reg`  in  ADDR_W  first register written; sampled with `start`.
- `count`  in  ADDR_W+1  number of words to load, 0..NUM_REGS; sampled with `start`.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a word this cycle.
- `in_data`  in  DATA_W  word to load.
- `write_reg`  out  ADDR_W  register-file write address.
- `write_data`  out  DATA_W  register-file write data.
- `RegWrite`  out  1  register-file write enable.
- `read_reg_1`  out  ADDR_W  register-file read address (verify pass only).
- `read_data_1`  in  DATA_W  register-file combinational read data.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  sticky; cleared by the next accepted `start`.
- `words_written`  out  ADDR_W+1  words written in the current or last load.

## Operation
- States: IDLE, LOAD, VERIFY (only when the macro is defined), FINISH.
- IDLE:
  - `start`=1 with `count`=0: go to FINISH, no writes.
  - `start`=1 with `count`>NUM_REGS: set `error`, go to FINISH, no writes.
  - Otherwise: latch `base_reg` and `count`, clear `error` and `words_written`, go to LOAD.
- `start` outside IDLE is ignored.
- LOAD:
  - `in_ready`=1 until `count` words have been accepted.
  - A word is accepted when `in_valid`&&`in_ready`.
  - Each accepted word is registered into `write_data` with address `write_reg` = (`base_reg` + index) mod NUM_REGS. Addresses wrap: base 6, count 3 gives 6, 7, 0.
  - `RegWrite` is high for exactly one cycle per accepted word. It is never high without an accepted word.
  - `words_written` increments with each `RegWrite` cycle.
- After the last write: go to VERIFY if the macro is defined, otherwise go to FINISH.
- VERIFY:
  - Drives `read_reg_1` through the same address sequence, one address per cycle.
  - Accumulates the XOR of `read_data_1`.
  - Compares the result with the XOR of all accepted words, which is accumulated during LOAD.
  - A mismatch sets `error`.
- FINISH: pulse `done` for one cycle, then return to IDLE.
- Reset mid-operation:
  - All state returns to IDLE and `RegWrite` drops immediately.
  - Registers already written keep their new values. No rollback.
- Reset values: `in_ready` 0, `write_reg` 0, `write_data` 0, `RegWrite` 0, `read_reg_1` 0, `busy` 0, `done` 0, `error` 0, `words_written` 0.

## Timing
- `start` sampled at edge of cycle 0. `busy` and `in_ready` are high in cycle 1.
- Word accepted in cycle k: `RegWrite`/`write_reg`/`write_data` are valid in cycle k+1. The register file captures at the end of k+1.
- Full-rate input gives one write per cycle. Stalls (`in_valid`=0) insert no `RegWrite`.
- `in_ready` is 0 in the cycle after the final acceptance.
- Last acceptance at cycle k, no verify: `done` in cycle k+2, `busy` low in cycle k+2.
- Last acceptance at cycle k, with verify: reads occur in cycles k+2 … k+1+count, `done` in cycle k+2+count. `error` is valid in the `done` cycle.
- `count`=0 or illegal `count`: `done` in cycle 1, `busy` stays 0.
- `read_data_1` must be a combinational read of the file. A same-cycle write is not forwarded, and the verify pass never overlaps a write.

## Configuration
- `REGFILE_LOADER_VERIFY_EN` defined:
  - VERIFY state and XOR comparison are present.
  - `read_reg_1` is driven with read-back addresses.
- Macro undefined:
  - No VERIFY state; LOAD goes straight to FINISH.
  - `read_reg_1` is held at 0 and `read_data_1` is ignored.
  - `error` is set only by an illegal `count`.

## Test plan
- Reset, then `start` with base 0, count 8, words 0x00000001…0x00000008 at full rate -> 8 `RegWrite` pulses at addresses 0..7; register file holds 1..8; `done` 2 cycles after the last acceptance; `error`=0; `words_written`=8.
- Base 6, count 3, words 0xAAAA0000, 0xBBBB0000, 0xCCCC0000 -> writes to regs 6, 7, 0 in that order; regs 1..5 unchanged.
- Count 4 with `in_valid` toggling 1,0,0,1,1,0,1 -> exactly 4 `RegWrite` pulses, each one cycle after its acceptance; no write during gaps.
- Count 0 -> `done` in cycle 1, no `RegWrite`. Count 9 -> `done` in cycle 1, `error`=1, no `RegWrite`.
- With `REGFILE_LOADER_VERIFY_EN`, bench register model flips bit 0 of reg 2 after a count-8 load -> `error`=1 at `done`, 8 cycles later than without the macro.
- Assert `reset` after 3 of 8 words -> all outputs return to reset values asynchronously; regs 0..2 keep their written data; a new `start` with count 2 completes normally.
